mouse_pos_tracker: RTL
======================

MOUSE_POS_TRACKER -- requirements
Module: mouse_pos_tracker

Interface
REQ-001 Parameter MAX_X, default 799, SHALL be the largest legal xpos value.
REQ-002 Parameter MAX_Y, default 599, SHALL be the largest legal ypos value.
REQ-003 Parameter TIMEOUT, default 65000, SHALL be the maximum idle gap in pclk cycles between bytes of one packet.
REQ-004 pclk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 rx_data  input  8  SHALL be the PS/2 byte from the receiver, valid only when rx_valid=1.
REQ-007 rx_valid  input  1  SHALL be a one-cycle strobe per received byte, with no backpressure.
REQ-008 xpos  output  12  SHALL be the registered cursor column, range 0..MAX_X.
REQ-009 ypos  output  12  SHALL be the registered cursor row, range 0..MAX_Y, with 0 at the top.
REQ-010 left, right  output  1 each  SHALL be the registered button states from the last accepted packet.
REQ-011 pos_valid  output  1  SHALL pulse high for one cycle when xpos/ypos/buttons update.

Function
REQ-012 The FSM SHALL have the states WAIT_B0, WAIT_B1, WAIT_B2 and UPDATE.
REQ-013 In WAIT_B0, a byte with bit3=1 SHALL be latched as the header and the FSM SHALL move to WAIT_B1; a byte with bit3=0 SHALL be discarded, keeping the FSM in WAIT_B0 for resynchronisation.
REQ-014 In WAIT_B1, a byte SHALL be latched as the X delta and the FSM SHALL move to WAIT_B2; in WAIT_B2, a byte SHALL be latched as the Y delta and the FSM SHALL move to UPDATE.
REQ-015 UPDATE SHALL last exactly one cycle, then return to WAIT_B0; a byte arriving during UPDATE SHALL be processed as in WAIT_B0.
REQ-016 Header fields: bit0 left, bit1 right, bit4 X sign, bit5 Y sign, bit6 X overflow, bit7 Y overflow.
REQ-017 Each delta SHALL be the 9-bit two's-complement value {sign, data byte}; an axis with its overflow bit set SHALL use a delta of 0.
REQ-018 The new X SHALL be computed as signed 13-bit xpos+dx, clamped to 0 if negative and to MAX_X if greater than MAX_X.
REQ-019 The new Y SHALL be computed as signed 13-bit ypos-dy (mouse up = screen up), clamped to 0..MAX_Y.
REQ-020 On the cycle after the third byte's rx_valid, xpos, ypos, left and right SHALL take their new values and pos_valid SHALL be 1 (latency 1 cycle).
REQ-021 An idle counter SHALL clear on every rx_valid; in WAIT_B1/WAIT_B2, when the counter reaches TIMEOUT, the FSM SHALL return to WAIT_B0, discard the partial packet and leave the outputs unchanged.
REQ-022 The counter SHALL saturate at TIMEOUT and SHALL NOT wrap.
REQ-023 Outputs SHALL change only in UPDATE; pos_valid SHALL be 0 in all other states.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force the FSM to WAIT_B0, xpos=MAX_X/2 (399), ypos=MAX_Y/2 (299), left=right=0, pos_valid=0, and the idle counter to 0.
REQ-025 A reset asserted mid-packet SHALL discard the partial packet; the first byte after release SHALL be treated as a header candidate.

Structure
REQ-026 Header bit indices, the FSM state encoding, and the MAX_X/MAX_Y/TIMEOUT defaults SHALL reside in the shared package mouse_pkg.
REQ-027 Signed accumulate and clamp SHALL be a combinational sub-module, mouse_axis_clamp, instantiated once per axis; the Y instance SHALL receive a negated delta.

Verification
REQ-028 Reset release, then bytes 0x08,0x0A,0x05 -> xpos=409, ypos=294, pos_valid one cycle after the third byte.
REQ-029 From 399/299, bytes 0x39,0x00,0x00 (dx=-256, dy=-256, left=1) -> xpos=143, ypos=555, left=1.
REQ-030 From xpos=5, bytes 0x18,0xF0,0x00 (dx=-16) -> xpos=0; from xpos=795, bytes 0x08,0x7F,0x00 -> xpos=799.
REQ-031 Bytes 0x02 (bit3=0), then 0x08,0x01,0x01 -> 0x02 discarded, xpos+1, ypos-1, exactly one pos_valid.
REQ-032 Bytes 0x08,0x10, then a gap of TIMEOUT cycles, then 0x08,0x01,0x00 -> no update from the stale packet, xpos+1 only.
REQ-033 Header 0x48 (X overflow), 0x55, 0x03 -> xpos unchanged, ypos-3; and rst_n=0 pulsed after byte 1 -> outputs 399/299, next packet decodes cleanly.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared definitions for the PS/2 mouse position tracker:
// header bit map, FSM encoding, default screen size and idle timeout.
package mouse_pkg;

    localparam int MAX_X_DEF   = 799;
    localparam int MAX_Y_DEF   = 599;
    localparam int TIMEOUT_DEF = 65000;

    localparam int HDR_LEFT  = 0;
    localparam int HDR_RIGHT = 1;
    localparam int HDR_SYNC  = 3;
    localparam int HDR_XSIGN = 4;
    localparam int HDR_YSIGN = 5;
    localparam int HDR_XOVF  = 6;
    localparam int HDR_YOVF  = 7;

    typedef enum logic [1:0] {
        WAIT_B0 = 2'd0,
        WAIT_B1 = 2'd1,
        WAIT_B2 = 2'd2,
        UPDATE  = 2'd3
    } state_t;

    // Only the header fields the tracker actually uses.
    typedef struct packed {
        logic y_ovf;
        logic x_ovf;
        logic y_sign;
        logic x_sign;
        logic right;
        logic left;
    } hdr_t;

    function automatic hdr_t unpack_hdr(input logic [7:0] b);
        hdr_t h;
        h.left   = b[HDR_LEFT];
        h.right  = b[HDR_RIGHT];
        h.x_sign = b[HDR_XSIGN];
        h.y_sign = b[HDR_YSIGN];
        h.x_ovf  = b[HDR_XOVF];
        h.y_ovf  = b[HDR_YOVF];
        return h;
    endfunction

endpackage

// File: rtl/mouse_pos_tracker_if.sv
// Byte-in / position-out bundle of the mouse tracker.
// master: byte source + position consumer; slave: the tracker.
interface mouse_pos_tracker_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        right;
    logic        pos_valid;

    modport master (
        output rx_data, rx_valid,
        input  xpos, ypos, left, right, pos_valid
    );

    modport slave (
        input  rx_data, rx_valid,
        output xpos, ypos, left, right, pos_valid
    );

endinterface

// File: rtl/mouse_axis_clamp.sv
// One axis: new = pos + delta (signed 13-bit), clamped to 0..MAX.
// Ports: pos (current), delta (signed 10-bit), result (clamped).
module mouse_axis_clamp #(
    parameter int MAX = 799
) (
    input  logic [11:0]       pos,
    input  logic signed [9:0] delta,
    output logic [11:0]       result
);

    logic signed [12:0] sum;

    always_comb begin
        sum = $signed({1'b0, pos}) + $signed({{3{delta[9]}}, delta});
        result = sum[11:0];
        if (sum[12]) begin
            result = '0;
        end else if (sum > 13'(MAX)) begin
            result = 12'(MAX);
        end
    end

endmodule

// File: rtl/mouse_pos_tracker.sv
// Assembles 3-byte PS/2 mouse packets into a clamped cursor position.
// Ports: pclk, rst_n (async, active low), bus (slave: bytes in, position out).
module mouse_pos_tracker
    import mouse_pkg::*;
#(
    parameter int MAX_X   = MAX_X_DEF,
    parameter int MAX_Y   = MAX_Y_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic                pclk,
    input logic                rst_n,
    mouse_pos_tracker_if.slave bus
);

    localparam int              CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TO    = CW'(TIMEOUT);
    localparam logic [11:0]     X_RST = 12'(MAX_X / 2);
    localparam logic [11:0]     Y_RST = 12'(MAX_Y / 2);

    state_t          state;
    hdr_t            hdr;
    logic [7:0]      dx_byte;
    logic [CW-1:0]   idle_cnt;

    logic            timed_out;
    logic            hunt;
    logic [8:0]      dy9;
    logic [9:0]      dx;
    logic [9:0]      dy_neg;
    logic [11:0]     x_next;
    logic [11:0]     y_next;

    assign timed_out = (idle_cnt == TO);

    // UPDATE and a stalled partial packet both behave like WAIT_B0:
    // the byte on this cycle (if any) is a header candidate.
    assign hunt = (state == WAIT_B0) || (state == UPDATE) || timed_out;

    // The Y delta is used straight off rx_data so the result lands
    // on the same edge that accepts the third byte.
    always_comb begin
        dx     = hdr.x_ovf ? 10'd0 : {hdr.x_sign, hdr.x_sign, dx_byte};
        dy9    = hdr.y_ovf ? 9'd0 : {hdr.y_sign, bus.rx_data};
        dy_neg = -{dy9[8], dy9};
    end

    mouse_axis_clamp #(.MAX(MAX_X)) u_x_clamp (
        .pos    (bus.xpos),
        .delta  (dx),
        .result (x_next)
    );

    // Screen Y grows downward, so mouse-up motion is subtracted.
    mouse_axis_clamp #(.MAX(MAX_Y)) u_y_clamp (
        .pos    (bus.ypos),
        .delta  (dy_neg),
        .result (y_next)
    );

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= WAIT_B0;
            hdr           <= '0;
            dx_byte       <= '0;
            idle_cnt      <= '0;
            bus.xpos      <= X_RST;
            bus.ypos      <= Y_RST;
            bus.left      <= 1'b0;
            bus.right     <= 1'b0;
            bus.pos_valid <= 1'b0;
        end else begin
            bus.pos_valid <= 1'b0;

            if (bus.rx_valid) begin
                idle_cnt <= '0;
            end else if (!timed_out) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (hunt) begin
                state <= WAIT_B0;
                if (bus.rx_valid && bus.rx_data[HDR_SYNC]) begin
                    hdr   <= unpack_hdr(bus.rx_data);
                    state <= WAIT_B1;
                end
            end else begin
                unique case (state)
                    WAIT_B1: begin
                        if (bus.rx_valid) begin
                            dx_byte <= bus.rx_data;
                            state   <= WAIT_B2;
                        end
                    end
                    WAIT_B2: begin
                        if (bus.rx_valid) begin
                            bus.xpos      <= x_next;
                            bus.ypos      <= y_next;
                            bus.left      <= hdr.left;
                            bus.right     <= hdr.right;
                            bus.pos_valid <= 1'b1;
                            state         <= UPDATE;
                        end
                    end
                    default: state <= WAIT_B0;
                endcase
            end
        end
    end

endmodule
